tpg_pattern_gen: RTL and testbench



---
 rtl/tpg_pattern_gen.sv | 168 ++++++++++++++++
 tb/tb_tpg_pattern_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpg_pattern_gen.sv
// Parametrised raster test-pattern generator with bars, ramps and checkerboard.
// Optional per-frame pixel checksum outputs are enabled by defining TPG_CHECKSUM_EN.
module tpg_pattern_gen #(
  parameter int unsigned PIXEL_W      = 10,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_BLANK      = 160,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_BLANK      = 45,
  parameter int unsigned NUM_BARS     = 8,
  parameter int unsigned CHECKER_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               line_valid,
  output logic               frame_valid,
  output logic               frame_start,
  output logic [15:0]        frame_count
`ifdef TPG_CHECKSUM_EN
  ,
  output logic [15:0]        frame_sum,
  output logic               sum_valid
`endif
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_BLANK;
  localparam int unsigned HW       = ($clog2(H_TOTAL) > CHECKER_LOG2) ? $clog2(H_TOTAL)
                                                                      : CHECKER_LOG2 + 1;
  localparam int unsigned VW       = ($clog2(V_TOTAL) > CHECKER_LOG2) ? $clog2(V_TOTAL)
                                                                      : CHECKER_LOG2 + 1;
  localparam int unsigned BAR_W    = H_ACTIVE / NUM_BARS;
  localparam int unsigned BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned BAR_STEP = ((2 ** PIXEL_W) - 1) / (NUM_BARS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q;
  logic [HW-1:0]      h_q;
  logic [VW-1:0]      v_q;
  logic [1:0]         mode_q;
  logic [15:0]        frame_count_q;
  logic [BW-1:0]      bar_cnt_q;
  logic [PIXEL_W-1:0] bar_val_q;
  logic [PIXEL_W-1:0] pixel_q;
  logic               line_valid_q, frame_valid_q, frame_start_q;

  logic               run, h_last, v_last, active_h, active_v;
  logic [PIXEL_W-1:0] h_pix, pattern;

  always_comb begin
    run      = (state_q == StRun);
    h_last   = (h_q == HW'(H_TOTAL - 1));
    v_last   = (v_q == VW'(V_TOTAL - 1));
    active_h = (h_q < HW'(H_ACTIVE));
    active_v = (v_q < VW'(V_ACTIVE));
    h_pix    = PIXEL_W'(h_q);
    pattern  = '0;
    case (mode_q)
      2'd0:    pattern = bar_val_q;
      2'd1:    pattern = h_pix;
      2'd2:    pattern = {PIXEL_W{h_q[CHECKER_LOG2] ^ v_q[CHECKER_LOG2]}};
      default: pattern = h_pix + PIXEL_W'(frame_count_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      h_q           <= '0;
      v_q           <= '0;
      mode_q        <= '0;
      frame_count_q <= '0;
      bar_cnt_q     <= '0;
      bar_val_q     <= '0;
      pixel_q       <= '0;
      line_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // Outputs lag the counters by one cycle.
      frame_valid_q <= run && active_v;
      line_valid_q  <= run && active_v && active_h;
      frame_start_q <= run && (h_q == '0) && (v_q == '0);
      pixel_q       <= (run && active_v && active_h) ? pattern : '0;

      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StRun;
            mode_q  <= mode;
            h_q     <= '0;
            v_q     <= '0;
          end
        end
        StRun: begin
          if (h_last) begin
            h_q <= '0;
            if (v_last) begin
              v_q           <= '0;
              frame_count_q <= frame_count_q + 16'd1;
              if (enable) mode_q  <= mode;
              else        state_q <= StIdle;
            end else begin
              v_q <= v_q + 1'b1;
            end
          end else begin
            h_q <= h_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Bar value steps every BAR_W pixels so no divider is needed.
      if (!run || h_last) begin
        bar_cnt_q <= '0;
        bar_val_q <= '0;
      end else if (active_h) begin
        if (bar_cnt_q == BW'(BAR_W - 1)) begin
          bar_cnt_q <= '0;
          bar_val_q <= bar_val_q + PIXEL_W'(BAR_STEP);
        end else begin
          bar_cnt_q <= bar_cnt_q + 1'b1;
        end
      end
    end
  end

  assign pixel_out   = pixel_q;
  assign line_valid  = line_valid_q;
  assign frame_valid = frame_valid_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

`ifdef TPG_CHECKSUM_EN
  logic        last_px_q, sum_valid_q;
  logic [15:0] sum_acc_q, sum_acc_d, frame_sum_q;

  // Accumulate on the registered pixel stream; frame_start restarts the sum.
  always_comb begin
    sum_acc_d = sum_acc_q;
    if (frame_start_q)     sum_acc_d = 16'(pixel_q);
    else if (line_valid_q) sum_acc_d = sum_acc_q + 16'(pixel_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_px_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_acc_q   <= '0;
      frame_sum_q <= '0;
    end else begin
      last_px_q   <= run && (v_q == VW'(V_ACTIVE - 1)) && (h_q == HW'(H_ACTIVE - 1));
      sum_valid_q <= last_px_q;
      sum_acc_q   <= sum_acc_d;
      if (last_px_q) frame_sum_q <= sum_acc_d;
    end
  end

  assign frame_sum = frame_sum_q;
  assign sum_valid = sum_valid_q;
`else
  // Checksum path compiled out.
`endif

endmodule

// File: tb/tb_tpg_pattern_gen.sv
// Directed bench for tpg_pattern_gen on a 20x6 raster (16x4 active).
// Checksum checks are included when TPG_CHECKSUM_EN is defined.
module tb_tpg_pattern_gen;

  localparam int NFR = 120;
  localparam int NSLOT = 7;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [1:0]  mode;
  logic [7:0]  pixel_out;
  logic        line_valid, frame_valid, frame_start;
  logic [15:0] frame_count;
`ifdef TPG_CHECKSUM_EN
  logic [15:0] frame_sum;
  logic        sum_valid;
`endif

  tpg_pattern_gen #(
    .PIXEL_W(8), .H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(4), .V_BLANK(2),
    .NUM_BARS(4), .CHECKER_LOG2(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .pixel_out  (pixel_out),
    .line_valid (line_valid),
    .frame_valid(frame_valid),
    .frame_start(frame_start),
    .frame_count(frame_count)
`ifdef TPG_CHECKSUM_EN
    ,
    .frame_sum  (frame_sum),
    .sum_valid  (sum_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endfunction

  typedef struct {
    int          slot;
    int          idx;
    logic [7:0]  pix;
    logic [2:0]  flags;  // {line_valid, frame_valid, frame_start}
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(int s, int i, int p, logic [2:0] f, int c);
    vec_t v;
    v.slot = s; v.idx = i; v.pix = 8'(p); v.flags = f; v.fc = 16'(c);
    vecs.push_back(v);
  endfunction

  logic [7:0]  cap_pix [NSLOT][NFR];
  logic        cap_lv  [NSLOT][NFR];
  logic        cap_fv  [NSLOT][NFR];
  logic        cap_fs  [NSLOT][NFR];
  logic [15:0] cap_fc  [NSLOT][NFR];
  logic        cap_sv  [NSLOT][NFR];
  logic [15:0] cap_sum [NSLOT];

  // Waits for frame_start, then records 120 samples; optionally changes inputs mid-frame.
  task automatic capture(input int slot, input int mid_idx, input logic mid_en,
                         input logic [1:0] mid_mode, output int lat);
    int  waited = 0;
    logic found = 1'b0;
    while (!found && waited < 400) begin
      @(negedge clk);
      waited++;
      if (frame_start === 1'b1) found = 1'b1;
    end
    lat = waited;
    chk($sformatf("frame_start_seen_slot%0d", slot), 32'(found), 32'd1);
    if (!found) return;
    for (int i = 0; i < NFR; i++) begin
      if (i > 0) @(negedge clk);
      cap_pix[slot][i] = pixel_out;
      cap_lv[slot][i]  = line_valid;
      cap_fv[slot][i]  = frame_valid;
      cap_fs[slot][i]  = frame_start;
      cap_fc[slot][i]  = frame_count;
`ifdef TPG_CHECKSUM_EN
      cap_sv[slot][i]  = sum_valid;
      if (i == 76) cap_sum[slot] = frame_sum;
`else
      cap_sv[slot][i]  = 1'b0;
      if (i == 76) cap_sum[slot] = 16'd0;
`endif
      if (i == mid_idx) begin
        enable = mid_en;
        mode   = mid_mode;
      end
    end
  endtask

  task automatic wait_fs(input string name);
    int   waited = 0;
    logic found = 1'b0;
    while (!found && waited < 400) begin
      @(negedge clk);
      waited++;
      if (frame_start === 1'b1) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic idle_check(input string name, input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (pixel_out !== 8'd0 || line_valid !== 1'b0 || frame_valid !== 1'b0 ||
          frame_start !== 1'b0) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag, input logic [15:0] fc_req);
    chk({tag, "_pixel"}, 32'(pixel_out), 32'd0);
    chk({tag, "_line_valid"}, 32'(line_valid), 32'd0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(fc_req));
`ifdef TPG_CHECKSUM_EN
    chk({tag, "_frame_sum"}, 32'(frame_sum), 32'd0);
    chk({tag, "_sum_valid"}, 32'(sum_valid), 32'd0);
`endif
  endtask

  initial begin
    int lat;
    int lv_n, fv_n, fs_n, sv_n, ramp_bad;

    // slot, idx, pixel, {lv,fv,fs}, frame_count  (idx = v*20 + h)
    addv(0,   0,   0, 3'b111, 0);  // mode 0 bars
    addv(0,   5,  85, 3'b110, 0);
    addv(0,  10, 170, 3'b110, 0);
    addv(0,  15, 255, 3'b110, 0);
    addv(0,  16,   0, 3'b010, 0);
    addv(0,  65,  85, 3'b110, 0);  // after mid-frame mode change
    addv(0,  79,   0, 3'b010, 0);
    addv(0,  80,   0, 3'b000, 0);
    addv(0, 119,   0, 3'b000, 1);
    addv(1,   0,   0, 3'b111, 1);  // mode 1 ramp
    addv(1,   7,   7, 3'b110, 1);
    addv(1,  35,  15, 3'b110, 1);
    addv(1,  67,   7, 3'b110, 1);
    addv(1, 100,   0, 3'b000, 1);
    addv(2,   0,   0, 3'b111, 2);  // mode 2 checker
    addv(2,   2, 255, 3'b110, 2);
    addv(2,  40, 255, 3'b111 & 3'b110, 2);
    addv(2,  42,   0, 3'b110, 2);
    addv(2,  61, 255, 3'b110, 2);
    addv(2,  63,   0, 3'b110, 2);
    addv(3,   0,   0, 3'b111, 0);  // mode 3 moving ramp
    addv(4,   0,   1, 3'b111, 1);
    addv(5,   0,   2, 3'b111, 2);
    addv(4,   9,  10, 3'b110, 1);
    addv(5,  35,  17, 3'b110, 2);
    addv(3, 119,   0, 3'b000, 1);
    addv(6,   0,   0, 3'b111, 0);  // count wrapped to 0
    addv(6,  45,   5, 3'b110, 0);
    addv(6,  79,   0, 3'b010, 0);  // enable dropped, frame still completes
    addv(6, 119,   0, 3'b000, 1);

    for (int s = 0; s < NSLOT; s++) begin
      cap_sum[s] = '0;
      for (int i = 0; i < NFR; i++) begin
        cap_pix[s][i] = 'x; cap_lv[s][i] = 'x; cap_fv[s][i] = 'x;
        cap_fs[s][i] = 'x; cap_fc[s][i] = 'x; cap_sv[s][i] = 'x;
      end
    end

    // Reset and idle
    reset = 1'b1; enable = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset", 16'd0);
    reset = 1'b0;
    idle_check("idle_50_cycles", 50);
    chk("idle_frame_count", 32'(frame_count), 32'd0);

    // Three frames, each switching mode mid-frame for the next one
    enable = 1'b1; mode = 2'd0;
    capture(0, 60, 1'b1, 2'd1, lat);
    chk("start_latency", 32'(lat), 32'd2);
    capture(1, 60, 1'b1, 2'd2, lat);
    chk("back_to_back_latency", 32'(lat), 32'd1);
    capture(2, 60, 1'b1, 2'd3, lat);

    // Reset at h=5, v=2
    wait_fs("reset_test_frame_start");
    repeat (44) @(negedge clk);
    chk("pre_reset_line_valid", 32'(line_valid), 32'd1);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midframe_reset", 16'd0);
    reset = 1'b0;
    idle_check("after_reset_no_valids", 30);

    // Moving ramp over three frames from frame_count 0
    enable = 1'b1; mode = 2'd3;
    capture(3, -1, 1'b1, 2'd3, lat);
    chk("restart_latency", 32'(lat), 32'd2);
    capture(4, -1, 1'b1, 2'd3, lat);
    capture(5, -1, 1'b1, 2'd3, lat);

    // Frame counter wrap
    force dut.frame_count_q = 16'hFFFE;
    #1;
    release dut.frame_count_q;
    wait_fs("wrap_fs_a");
    chk("wrap_count_fffe", 32'(frame_count), 32'h0000FFFE);
    wait_fs("wrap_fs_b");
    chk("wrap_count_ffff", 32'(frame_count), 32'h0000FFFF);

    // Enable dropped on line 1: frame completes, then idle
    capture(6, 25, 1'b0, 2'd3, lat);
    idle_check("idle_after_enable_drop", 50);
    chk("idle_count_held", 32'(frame_count), 32'd1);

    for (int k = 0; k < vecs.size(); k++) begin
      int s, i;
      s = vecs[k].slot;
      i = vecs[k].idx;
      chk($sformatf("vec%0d_pixel_s%0d_i%0d", k, s, i), 32'(cap_pix[s][i]), 32'(vecs[k].pix));
      chk($sformatf("vec%0d_flags_s%0d_i%0d", k, s, i),
          32'({cap_lv[s][i], cap_fv[s][i], cap_fs[s][i]}), 32'(vecs[k].flags));
      chk($sformatf("vec%0d_fcount_s%0d_i%0d", k, s, i), 32'(cap_fc[s][i]), 32'(vecs[k].fc));
    end

    for (int s = 0; s < NSLOT; s++) begin
      lv_n = 0; fv_n = 0; fs_n = 0;
      for (int i = 0; i < NFR; i++) begin
        if (cap_lv[s][i] === 1'b1) lv_n++;
        if (cap_fv[s][i] === 1'b1) fv_n++;
        if (cap_fs[s][i] === 1'b1) fs_n++;
      end
      chk($sformatf("line_valid_count_s%0d", s), 32'(lv_n), 32'd64);
      chk($sformatf("frame_valid_count_s%0d", s), 32'(fv_n), 32'd80);
      chk($sformatf("frame_start_count_s%0d", s), 32'(fs_n), 32'd1);
    end

    ramp_bad = 0;
    for (int i = 0; i < NFR; i++)
      if ((i % 20) < 16 && (i / 20) < 4 && cap_pix[1][i] !== 8'(i % 20)) ramp_bad++;
    chk("ramp_all_active_pixels", 32'(ramp_bad), 32'd0);

`ifdef TPG_CHECKSUM_EN
    sv_n = 0;
    for (int i = 0; i < NFR; i++) if (cap_sv[1][i] === 1'b1) sv_n++;
    chk("checksum_frame_sum", 32'(cap_sum[1]), 32'd480);
    chk("checksum_sum_valid_pos", 32'(cap_sv[1][76]), 32'd1);
    chk("checksum_sum_valid_count", 32'(sv_n), 32'd1);
`else
    sv_n = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
